// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch port and
// the data port. It sequences single accesses and fixed-length read bursts, and aborts on ack timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [INST_WIDTH-1:0] i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_burst,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int ISEL  = $clog2(INST_WIDTH / 8);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_ACC   = 2'd1,
        D_ACC   = 2'd2,
        D_BURST = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  last_was_d_q, last_was_d_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            beat_q, beat_d;
    logic [7:0]            wait_q, wait_d;
    logic                  i_rvalid_q, i_rvalid_d;
    logic                  i_err_q, i_err_d;
    logic [INST_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic                  d_rvalid_q, d_rvalid_d;
    logic                  d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  timed_out;
    logic                  unused_addr_bits;

    // Handshake: a requester holds req until it sees gnt; gnt is only ever given in IDLE.
    // mem_req stays high until mem_ack, or drops when the wait counter hits TIMEOUT.
    always_comb begin
        state_d      = state_q;
        last_was_d_d = last_was_d_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        i_rvalid_d   = 1'b0;
        i_err_d      = i_err_q;
        i_rdata_d    = i_rdata_q;
        d_rvalid_d   = 1'b0;
        d_err_d      = d_err_q;
        d_rdata_d    = d_rdata_q;
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        timed_out    = (wait_q == 8'(TIMEOUT));

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (d_req && (!i_req || !last_was_d_q)) begin
                    d_gnt        = 1'b1;
                    addr_d       = d_addr;
                    we_d         = d_we;
                    wdata_d      = d_wdata;
                    beat_d       = 5'd0;
                    wait_d       = 8'd0;
                    last_was_d_d = 1'b1;
                    state_d      = (d_burst && !d_we) ? D_BURST : D_ACC;
                end else if (i_req) begin
                    i_gnt        = 1'b1;
                    addr_d       = i_addr;
                    we_d         = 1'b0;
                    beat_d       = 5'd0;
                    wait_d       = 8'd0;
                    last_was_d_d = 1'b0;
                    state_d      = I_ACC;
                end
            end
            I_ACC: begin
                if (timed_out) begin
                    i_rvalid_d = 1'b1;
                    i_err_d    = 1'b1;
                    i_rdata_d  = NOP;
                    state_d    = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        i_rvalid_d = 1'b1;
                        i_err_d    = 1'b0;
                        i_rdata_d  = addr_q[ISEL] ? mem_rdata[2*INST_WIDTH-1:INST_WIDTH]
                                                  : mem_rdata[INST_WIDTH-1:0];
                        state_d    = IDLE;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            D_ACC, D_BURST: begin
                if (timed_out) begin
                    d_rvalid_d = 1'b1;
                    d_err_d    = 1'b1;
                    d_rdata_d  = '0;
                    state_d    = IDLE;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (state_q == D_ACC) && we_q;
                    if (mem_ack) begin
                        d_rvalid_d = 1'b1;
                        d_err_d    = 1'b0;
                        d_rdata_d  = mem_rdata;
                        if (state_q == D_ACC || beat_q == 5'(BURST_LEN - 1)) begin
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_q + 5'd1;
                            addr_d = addr_q + ADDR_WIDTH'(BYTES);
                            wait_d = 8'd0;
                        end
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_was_d_q <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            beat_q       <= 5'd0;
            wait_q       <= 8'd0;
            i_rvalid_q   <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= NOP;
            d_rvalid_q   <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_was_d_q <= last_was_d_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            i_rvalid_q   <= i_rvalid_d;
            i_err_q      <= i_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rvalid_q   <= d_rvalid_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_addr         = {addr_q[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
    assign mem_wdata        = wdata_q;
    assign i_rvalid         = i_rvalid_q;
    assign i_err            = i_err_q;
    assign i_rdata          = i_rdata_q;
    assign d_rvalid         = d_rvalid_q;
    assign d_err            = d_err_q;
    assign d_rdata          = d_rdata_q;
    assign dbg_state_o      = state_q;
    assign unused_addr_bits = ^addr_q[ISEL-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model of grants, memory accesses and
// responses, driven by directed scenarios and random traffic.
module tb_mem_port_arbiter;
  localparam int BL = 4;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_burst, d_gnt, d_rvalid, d_err;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_burst(d_burst), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  bit          busy, cur_d, cur_we, cur_hi, last_d;
  logic [63:0] cur_addr, cur_wdata;
  int          beats_left, lat, lat_cnt;
  bit          due_i, due_d, due_d_rd;
  logic [31:0] exp_i;
  logic [63:0] exp_d;
  bit          i_pend, d_pend;
  int          gen_mode, force_lat;
  bit          force_data_en;
  logic [63:0] force_data;
  logic [63:0] acc_log[$];
  logic [63:0] exp_q[$];
  bit          gnt_log[$];
  int          i_rv_cnt, d_rv_cnt;

  task automatic new_lat();
    lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
    lat_cnt = 0;
  endtask

  task automatic reset_model();
    busy = 0; due_i = 0; due_d = 0; last_d = 0; i_pend = 0; d_pend = 0;
    i_req = 0; d_req = 0; mem_ack = 0;
    acc_log.delete(); gnt_log.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive requests and memory ack, then check all outputs against the model.
  task automatic step();
    bit egi, egd;
    @(negedge clk);
    if (gen_mode == 1) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_addr = {$urandom, $urandom};
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = $urandom_range(0, 1); d_burst = $urandom_range(0, 1);
        d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      end
    end else if (gen_mode == 2) begin
      if (!i_pend) begin i_pend = 1; i_addr = {$urandom, $urandom}; end
      if (!d_pend) begin
        d_pend = 1; d_we = 0; d_burst = 0; d_addr = {$urandom, $urandom};
      end
    end
    i_req = i_pend;
    d_req = d_pend;
    mem_ack = 0;
    if (busy) begin
      if (lat_cnt >= lat) begin
        mem_ack = 1;
        mem_rdata = force_data_en ? force_data : {$urandom, $urandom};
      end else begin
        lat_cnt++;
      end
    end
    #1;
    total++;
    if (i_rvalid !== due_i) begin bad++; $display("FAIL i_rvalid got=%b exp=%b", i_rvalid, due_i); end
    if (due_i) begin
      i_rv_cnt++;
      total++;
      if (i_rdata !== exp_i || i_err !== 1'b0) begin
        bad++; $display("FAIL i_resp got=%h/%b exp=%h/0", i_rdata, i_err, exp_i);
      end
    end
    total++;
    if (d_rvalid !== due_d) begin bad++; $display("FAIL d_rvalid got=%b exp=%b", d_rvalid, due_d); end
    if (due_d) begin
      d_rv_cnt++;
      total++;
      if (d_err !== 1'b0 || (due_d_rd && d_rdata !== exp_d)) begin
        bad++; $display("FAIL d_resp got=%h/%b exp=%h/0", d_rdata, d_err, exp_d);
      end
    end
    due_i = 0;
    due_d = 0;
    egd = !busy && d_pend && (!i_pend || !last_d);
    egi = !busy && i_pend && !egd;
    total++;
    if ({i_gnt, d_gnt} !== {egi, egd}) begin
      bad++; $display("FAIL gnt got=%b%b exp=%b%b", i_gnt, d_gnt, egi, egd);
    end
    total++;
    if (mem_req !== busy) begin bad++; $display("FAIL mem_req got=%b exp=%b", mem_req, busy); end
    if (busy && mem_ack) begin
      acc_log.push_back(mem_addr);
      total++;
      if (mem_addr !== cur_addr || mem_we !== (cur_d && cur_we) ||
          (cur_d && cur_we && mem_wdata !== cur_wdata)) begin
        bad++;
        $display("FAIL access got=%h we=%b wd=%h exp=%h we=%b wd=%h", mem_addr, mem_we,
                 mem_wdata, cur_addr, cur_d && cur_we, cur_wdata);
      end
      if (!cur_d) begin
        due_i = 1; exp_i = cur_hi ? mem_rdata[63:32] : mem_rdata[31:0];
      end else begin
        due_d = 1; due_d_rd = !cur_we; exp_d = mem_rdata;
      end
      beats_left--;
      cur_addr = cur_addr + 64'd8;
      new_lat();
      if (beats_left == 0) busy = 0;
    end
    if (egd) begin
      busy = 1; cur_d = 1; cur_we = d_we; cur_wdata = d_wdata;
      cur_addr = {d_addr[63:3], 3'b000};
      beats_left = (d_burst && !d_we) ? BL : 1;
      last_d = 1; d_pend = 0; gnt_log.push_back(1'b1); new_lat();
    end else if (egi) begin
      busy = 1; cur_d = 0; cur_we = 0; cur_hi = i_addr[2];
      cur_addr = {i_addr[63:3], 3'b000};
      beats_left = 1; last_d = 0; i_pend = 0; gnt_log.push_back(1'b0); new_lat();
    end
  endtask

  task automatic drain();
    int n = 0;
    step();
    while ((busy || i_pend || d_pend || due_i || due_d) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n >= 300) begin bad++; $display("FAIL drain_timeout got=%0d exp<300", n); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err});
    end
    total++;
    if (i_rdata !== 32'h0000_0013 || d_rdata !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h exp=00000013/0", i_rdata, d_rdata);
    end
    total++;
    if ({mem_req, mem_we} !== 2'b00 || mem_addr !== 64'h0 || mem_wdata !== 64'h0) begin
      bad++; $display("FAIL reset_mem got=%b%b %h %h exp=0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single_fetch();
    gen_mode = 0; force_lat = 2; force_data_en = 1;
    force_data = 64'h00A0_0093_0000_0013;
    i_rv_cnt = 0;
    i_pend = 1; i_addr = 64'h104;
    drain();
    total++;
    if (i_rv_cnt !== 1 || i_rdata !== 32'h00A0_0093 || i_err !== 1'b0) begin
      bad++; $display("FAIL single_fetch got=%0d/%h/%b exp=1/00a00093/0", i_rv_cnt, i_rdata, i_err);
    end
    force_lat = -1; force_data_en = 0;
  endtask

  task automatic test_contention();
    int n = 0;
    do_reset();
    gen_mode = 2;
    while (gnt_log.size() < 4 && n < 200) begin step(); n++; end
    gen_mode = 0;
    drain();
    exp_q = '{64'd1, 64'd0, 64'd1, 64'd0};
    total++;
    if (gnt_log.size() < 4) begin
      bad++; $display("FAIL contention_count got=%0d exp>=4", gnt_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (64'(gnt_log[k]) !== exp_q[k]) begin
          bad++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", k, gnt_log[k], exp_q[k]);
          break;
        end
      end
    end
  endtask

  task automatic test_burst(input logic [63:0] base, input logic [63:0] a0, input logic [63:0] a1,
                            input logic [63:0] a2, input logic [63:0] a3);
    gen_mode = 0;
    acc_log.delete();
    d_rv_cnt = 0;
    d_pend = 1; d_we = 0; d_burst = 1; d_addr = base; d_wdata = 64'h0;
    drain();
    exp_q = '{a0, a1, a2, a3};
    total++;
    if (acc_log.size() != 4 || d_rv_cnt != 4) begin
      bad++; $display("FAIL burst_beats got=%0d/%0d exp=4/4", acc_log.size(), d_rv_cnt);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc_log[k] !== exp_q[k]) begin
          bad++; $display("FAIL burst_addr idx=%0d got=%h exp=%h", k, acc_log[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_write();
    gen_mode = 0;
    acc_log.delete();
    d_rv_cnt = 0;
    d_pend = 1; d_we = 1; d_burst = 1; d_addr = 64'h2468; d_wdata = {$urandom, $urandom};
    drain();
    total++;
    if (acc_log.size() != 1 || d_rv_cnt != 1) begin
      bad++; $display("FAIL write_single got=%0d/%0d exp=1/1", acc_log.size(), d_rv_cnt);
    end
  endtask

  task automatic test_random();
    gen_mode = 1;
    repeat (800) step();
    gen_mode = 0;
    drain();
  endtask

  task automatic test_timeout();
    int n = 0;
    int nreq = 0;
    bit hit = 0;
    do_reset();
    @(negedge clk);
    i_addr = 64'h40; i_req = 1;
    #1;
    total++;
    if (i_gnt !== 1'b1) begin bad++; $display("FAIL timeout_gnt got=%b exp=1", i_gnt); end
    @(negedge clk);
    i_req = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (i_rvalid) begin hit = 1; break; end
      if (mem_req) nreq++;
      n++;
      @(negedge clk);
    end
    total++;
    if (!hit || n != TO + 1 || nreq != TO) begin
      bad++; $display("FAIL timeout_latency got=%0d/%0d exp=%0d/%0d", n, nreq, TO + 1, TO);
    end
    total++;
    if (i_err !== 1'b1 || i_rdata !== 32'h0000_0013 || mem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_resp got=%b/%h/%b exp=1/00000013/0", i_err, i_rdata, mem_req);
    end
    @(negedge clk);
    #1;
    total++;
    if (i_rvalid !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_after got=%b/%b exp=0/0", i_rvalid, mem_req);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray = 0;
    do_reset();
    @(negedge clk);
    d_req = 1; d_we = 0; d_burst = 1; d_addr = 64'h300;
    @(negedge clk);
    d_req = 0; mem_ack = 1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    mem_ack = 0;
    #1;
    total++;
    if (d_rvalid !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 64'h308) begin
      bad++; $display("FAIL midburst_pre got=%b/%b/%h exp=1/1/308", d_rvalid, mem_req, mem_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || d_rvalid !== 1'b0 || mem_addr !== 64'h0 || d_rdata !== 64'h0 ||
        dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL midburst_async got=%b/%b/%h/%h/%0d exp=0/0/0/0/0", mem_req, d_rvalid,
               mem_addr, d_rdata, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (d_rvalid || i_rvalid || mem_req) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL midburst_stray got=%0d exp=0", stray); end
    reset_model();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_burst = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    gen_mode = 0; force_lat = -1; force_data_en = 0; force_data = 0;
    i_rv_cnt = 0; d_rv_cnt = 0;
    reset_model();
    test_reset();
    test_single_fetch();
    test_contention();
    test_burst(64'h1F4, 64'h1F0, 64'h1F8, 64'h200, 64'h208);
    test_burst(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8, 64'h10);
    test_write();
    test_random();
    test_timeout();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported, 64-bit-wide memory between the instruction-fetch port and the data port of the core. It performs round-robin arbitration, latches the winning request, and sequences single accesses and fixed-length data read bursts. It drives a req/ack memory interface, returns responses to each requester, and aborts accesses that are never acknowledged.

## Interface
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, memory/data-port word width (bytes per beat = DATA_WIDTH/8)
- INST_WIDTH, 32, instruction width
- BURST_LEN, 4, beats per data read burst (2..16)
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction fetch request, held until i_gnt
- i_addr  in  ADDR_WIDTH  fetch byte address
- i_gnt  out  1  request accepted this cycle (combinational)
- i_rvalid  out  1  one-cycle response strobe
- i_rdata  out  INST_WIDTH  fetched instruction
- i_err  out  1  response is a timeout abort (valid with i_rvalid)
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_burst  in  1  read burst of BURST_LEN beats (ignored when d_we=1)
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  write data
- d_gnt  out  1  request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle response strobe, once per beat (writes: one completion strobe)
- d_rdata  out  DATA_WIDTH  read data
- d_err  out  1  timeout abort (valid with d_rvalid)
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  word-aligned address (low log2(DATA_WIDTH/8) bits zero)
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  access complete; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  read data

## Operation
- States: IDLE, I_ACC, D_ACC, D_BURST.
- Arbitration happens only in IDLE. If exactly one request is present, it wins. If both are present, the side not granted last wins. A last_grant pointer is reset to I, so D wins the first tie.
- The winner's gnt is asserted combinationally in IDLE. Its address, we, wdata and burst flag are latched at that edge. State moves to I_ACC, D_ACC (single access or write) or D_BURST.
- In an access state: mem_req=1, driving latched values. On mem_ack, data is captured and the response strobe fires next cycle.
- I side: mem_we=0. i_rdata = mem_rdata[63:32] if latched addr[2]=1, else [31:0].
- D_BURST: beat k uses address base_aligned + k*(DATA_WIDTH/8). Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently). The beat counter increments on each mem_ack. After beat BURST_LEN-1 is acked, state returns to IDLE. mem_req stays high between beats.
- Timeout: a wait counter resets on entry to each access/beat and increments every cycle mem_ack=0. When it reaches TIMEOUT, mem_req drops, the response strobe fires with err=1 and rdata=0 (I side: 32'h00000013, a NOP), and state returns to IDLE. A burst aborted this way issues no further beats.
- Requests arriving outside IDLE are not granted. The requester must keep req asserted.
- mem_ack in IDLE is ignored.

## Timing
- Reset values: i_gnt=d_gnt=0 (no req), i_rvalid=d_rvalid=0, i_err=d_err=0, i_rdata=32'h00000013, d_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE, counters 0.
- Reset mid-access: mem_req drops asynchronously and no pending response strobe is issued.
- Single access: req/gnt in cycle N; mem_req from N+1; mem_ack earliest N+1; rvalid in ack+1. State is IDLE in ack+1, so a new grant is possible in that same cycle.
- Burst: beat k+1 presented the cycle after beat k's ack. d_rvalid fires one cycle after each ack.
- The abort strobe fires in the cycle after the counter reaches TIMEOUT, i.e. TIMEOUT+1 cycles after mem_req rose with no ack.

## Test plan
- Single fetch: i_req, i_addr=0x104; mem_ack 2 cycles later with mem_rdata=0x00A00093_00000013 -> i_rvalid once, i_rdata=0x00A00093, i_err=0.
- Simultaneous i_req/d_req after reset, held -> d granted first, then i. Repeated back-to-back contention alternates grants D,I,D,I.
- Read burst, BURST_LEN=4, d_addr=0x1F4 -> mem_addr 0x1F0, 0x1F8, 0x200, 0x208; four d_rvalid strobes with matching data; then IDLE.
- Burst at d_addr=0xFFFF_FFFF_FFFF_FFF8 -> addresses wrap to 0x0, 0x8, 0x10 after the first beat.
- Write with d_we=1 and d_burst=1 -> single mem_req with mem_we=1, mem_wdata=d_wdata; one d_rvalid.
- No mem_ack for 255 cycles -> i_rvalid with i_err=1, i_rdata=0x00000013, mem_req low. Assert rst mid-burst -> all outputs return to reset values immediately, with no stray rvalid.
